traffic_controller: RTL and testbench



---
 rtl/traffic_controller.sv | 102 ++++++++++
 tb/tb_traffic_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/traffic_controller.sv
// Two-road light controller: major green by default, minor served on sensor demand.
// Define ALL_RED_EN to insert all-red clearance states after each yellow.
module traffic_controller #(
  parameter int MAJ_GREEN_MIN = 8,
  parameter int YELLOW_TIME   = 2,
  parameter int MIN_GREEN_MIN = 3,
  parameter int MIN_GREEN_MAX = 6,
  parameter int ALL_RED_TIME  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  output logic [2:0] major,
  output logic [2:0] minor
);

`ifdef ALL_RED_EN
  typedef enum logic [2:0] {
    MAJ_G, MAJ_Y, MIN_G, MIN_Y, AR1, AR2
  } state_t;
  localparam logic [7:0] L_AR = 8'(ALL_RED_TIME - 1);
`else
  typedef enum logic [1:0] {
    MAJ_G, MAJ_Y, MIN_G, MIN_Y
  } state_t;
`endif

  localparam logic [7:0] L_MAJ = 8'(MAJ_GREEN_MIN - 1);
  localparam logic [7:0] L_YEL = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] L_MNL = 8'(MIN_GREEN_MIN - 1);
  localparam logic [7:0] L_MNH = 8'(MIN_GREEN_MAX - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_timer;
  logic [2:0] r_major;
  logic [2:0] r_minor;
  logic       w_yel_done;
  logic [5:0] w_lamps;

  assign w_yel_done = (r_timer == L_YEL);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MAJ_G:
        if (r_timer >= L_MAJ && sensor)
          w_next = MAJ_Y;
`ifdef ALL_RED_EN
      MAJ_Y: if (w_yel_done) w_next = AR1;
      AR1:   if (r_timer == L_AR) w_next = MIN_G;
      MIN_Y: if (w_yel_done) w_next = AR2;
      AR2:   if (r_timer == L_AR) w_next = MAJ_G;
`else
      MAJ_Y: if (w_yel_done) w_next = MIN_G;
      MIN_Y: if (w_yel_done) w_next = MAJ_G;
`endif
      MIN_G:
        if ((r_timer >= L_MNL && !sensor) ||
            r_timer == L_MNH)
          w_next = MIN_Y;
      default: w_next = MAJ_G;
    endcase
  end

  // Lamps are registered from the next state so they track r_state exactly.
  always_comb begin
    w_lamps = {RED, RED};
    unique case (w_next)
      MAJ_G:   w_lamps = {GRN, RED};
      MAJ_Y:   w_lamps = {YEL, RED};
      MIN_G:   w_lamps = {RED, GRN};
      MIN_Y:   w_lamps = {RED, YEL};
      default: w_lamps = {RED, RED};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= MAJ_G;
      r_timer <= 8'd0;
      r_major <= GRN;
      r_minor <= RED;
    end else begin
      r_state <= w_next;
      r_major <= w_lamps[5:3];
      r_minor <= w_lamps[2:0];
      if (w_next != r_state)
        r_timer <= 8'd0;
      else if (r_timer != 8'hFF)
        r_timer <= r_timer + 8'd1;
    end
  end

  assign major = r_major;
  assign minor = r_minor;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller; lamp sequences hand-derived
// from the default dwell parameters, one-hot checked every cycle.
module tb_traffic_controller;

  logic       clock;
  logic       reset;
  logic       sensor;
  logic [2:0] major;
  logic [2:0] minor;

  localparam logic [5:0] L_MAJ_G = 6'b001_100;
  localparam logic [5:0] L_MAJ_Y = 6'b010_100;
  localparam logic [5:0] L_MIN_G = 6'b100_001;
  localparam logic [5:0] L_MIN_Y = 6'b100_010;
  localparam logic [5:0] L_AR    = 6'b100_100;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 0;

  traffic_controller dut (
    .clock  (clock),
    .reset  (reset),
    .sensor (sensor),
    .major  (major),
    .minor  (minor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp
  );
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %b expected %b",
               tag, got, exp);
  endtask

  // Check current lamps, then advance one cycle; repeated n times.
  task automatic expect_run(
    input string      tag,
    input int         n,
    input logic [5:0] exp
  );
    for (int i = 0; i < n; i++) begin
      check(tag, {major, minor}, exp);
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input logic s);
    sensor = s;
    reset  = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
  endtask

  always @(negedge clock)
    if (mon_en)
      check("onehot",
            {4'b0, $onehot(major), $onehot(minor)},
            6'b11);

  initial begin
    reset  = 1'b1;
    sensor = 1'b0;

    // Idle: no demand, major green forever
    do_reset(1'b0);
    mon_en = 1;
    expect_run("idle_majg", 50, L_MAJ_G);

    // Sensor held high: full cycle with minor max cap
    do_reset(1'b1);
    expect_run("hold_majg", 8, L_MAJ_G);
    expect_run("hold_majy", 2, L_MAJ_Y);
`ifdef ALL_RED_EN
    expect_run("hold_ar1", 1, L_AR);
`endif
    expect_run("hold_ming", 6, L_MIN_G);
    expect_run("hold_miny", 2, L_MIN_Y);
`ifdef ALL_RED_EN
    expect_run("hold_ar2", 1, L_AR);
`endif
    expect_run("hold_majg2", 8, L_MAJ_G);
    expect_run("hold_majy2", 1, L_MAJ_Y);

    // 5-cycle demand after the major minimum
    do_reset(1'b0);
    expect_run("dem_wait", 10, L_MAJ_G);
    sensor = 1'b1;
    expect_run("dem_majg", 1, L_MAJ_G);
    expect_run("dem_majy", 2, L_MAJ_Y);
`ifdef ALL_RED_EN
    expect_run("dem_ar1", 1, L_AR);
    expect_run("dem_ming", 1, L_MIN_G);
    sensor = 1'b0;
    expect_run("dem_ming", 2, L_MIN_G);
`else
    expect_run("dem_ming", 2, L_MIN_G);
    sensor = 1'b0;
    expect_run("dem_ming", 1, L_MIN_G);
`endif
    expect_run("dem_miny", 2, L_MIN_Y);
`ifdef ALL_RED_EN
    expect_run("dem_ar2", 1, L_AR);
`endif
    expect_run("dem_majg", 12, L_MAJ_G);

    // Short pulse inside the major minimum is ignored
    do_reset(1'b0);
    expect_run("pulse_pre", 3, L_MAJ_G);
    sensor = 1'b1;
    expect_run("pulse_on", 1, L_MAJ_G);
    sensor = 1'b0;
    expect_run("pulse_post", 20, L_MAJ_G);

    // Reset during minor green restarts the major minimum
    do_reset(1'b1);
    expect_run("rst_majg", 8, L_MAJ_G);
    expect_run("rst_majy", 2, L_MAJ_Y);
`ifdef ALL_RED_EN
    expect_run("rst_ar1", 1, L_AR);
`endif
    expect_run("rst_ming", 2, L_MIN_G);
    reset = 1'b1;
    expect_run("rst_ming", 1, L_MIN_G);
    reset = 1'b0;
    expect_run("rst_after", 8, L_MAJ_G);
    expect_run("rst_majy2", 2, L_MAJ_Y);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
